// File: rtl/rename_regfile_ckpt.sv
// Renaming register file: architectural values, per-register ROB alias tags, circular checkpoint buffer.
// Reads are combinational with same-cycle commit forwarding; every state update lands on the next clk edge.
// rdy low freezes all state; ck_alloc while full is dropped (never queued), so the dispatcher must watch ck_full.
module rename_regfile_ckpt #(
   parameter int NREG   = 32,
   parameter int RIDX_W = 5,
   parameter int DATA_W = 32,
   parameter int ROB_W  = 4,
   parameter int NRP    = 2,
   parameter int NCKPT  = 4,
   parameter int CK_W   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     flush,
   input  logic [NRP*RIDX_W-1:0]    rd_idx,
   output logic [NRP*ROB_W-1:0]     rd_q,
   output logic [NRP*DATA_W-1:0]    rd_v,
   input  logic                     ren_valid,
   input  logic [RIDX_W-1:0]        ren_reg,
   input  logic [ROB_W-1:0]         ren_alias,
   input  logic                     cm_valid,
   input  logic [RIDX_W-1:0]        cm_reg,
   input  logic [ROB_W-1:0]         cm_alias,
   input  logic [DATA_W-1:0]        cm_data,
   input  logic                     ck_alloc,
   output logic [CK_W-1:0]          ck_alloc_id,
   output logic                     ck_full,
   output logic [CK_W:0]            ck_count,
   input  logic                     ck_release,
   input  logic                     ck_restore,
   input  logic [CK_W-1:0]          ck_restore_id
);

   logic [DATA_W-1:0] regs_q   [NREG];
   logic [ROB_W-1:0]  alias_q  [NREG];
   logic [ROB_W-1:0]  ckpt_q   [NCKPT][NREG];
   logic [CK_W-1:0]   head_q;
   logic [CK_W-1:0]   tail_q;
   logic [CK_W:0]     count_q;

   logic [ROB_W-1:0]  alias_cc [NREG];
   logic [ROB_W-1:0]  alias_nx [NREG];
   logic [ROB_W-1:0]  ckpt_cc  [NCKPT][NREG];
   logic [NCKPT-1:0]  slot_vld;

   logic              cm_en;
   logic              ren_en;
   logic              normal;
   logic              restore_act;
   logic              rel_acc;
   logic              alloc_acc;
   logic [CK_W-1:0]   head_nx;
   logic [CK_W-1:0]   rest_cnt;

   // x0 is never written, so its alias and value stay zero after reset
   assign cm_en       = cm_valid && (cm_reg != '0);
   assign ren_en      = ren_valid && (ren_reg != '0);
   assign normal      = !flush && !ck_restore;
   assign restore_act = !flush && ck_restore && slot_vld[ck_restore_id];
   // releasing the slot being restored would free it twice, so that combination drops the release
   assign rel_acc     = !flush && ck_release && (count_q != '0) &&
                        !(ck_restore && (ck_restore_id == head_q));
   assign alloc_acc   = normal && ck_alloc && !ck_full;
   assign head_nx     = head_q + CK_W'(rel_acc);
   assign rest_cnt    = ck_restore_id - head_nx;

   assign ck_alloc_id = tail_q;
   assign ck_count    = count_q;
   assign ck_full     = (count_q == (CK_W+1)'(NCKPT));

   // slot k is live when its distance from head is below the live count (pointers alone cannot tell full from empty)
   always_comb begin
      logic [CK_W-1:0] off;
      off      = '0;
      slot_vld = '0;
      for (int k = 0; k < NCKPT; k++) begin
         off         = CK_W'(k) - head_q;
         slot_vld[k] = ({1'b0, off} < count_q);
      end
   end

   // live alias table after commit-clear, then after rename (rename wins on the same register)
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         alias_cc[r] = alias_q[r];
         if (cm_en && (cm_reg == RIDX_W'(r)) && (alias_q[r] == cm_alias))
            alias_cc[r] = '0;
         alias_nx[r] = alias_cc[r];
         if (ren_en && (ren_reg == RIDX_W'(r)))
            alias_nx[r] = ren_alias;
      end
   end

   // scrub the retiring tag from every live snapshot so a later restore cannot resurrect it
   always_comb begin
      for (int k = 0; k < NCKPT; k++) begin
         for (int r = 0; r < NREG; r++) begin
            ckpt_cc[k][r] = ckpt_q[k][r];
            if (slot_vld[k] && cm_en && (cm_reg == RIDX_W'(r)) && (ckpt_q[k][r] == cm_alias))
               ckpt_cc[k][r] = '0;
         end
      end
   end

   // read ports: x0 reads zero, a matching same-cycle commit is forwarded, same-cycle rename is not visible
   always_comb begin
      logic [RIDX_W-1:0] idx;
      idx  = '0;
      rd_q = '0;
      rd_v = '0;
      for (int p = 0; p < NRP; p++) begin
         idx = rd_idx[p*RIDX_W +: RIDX_W];
         if (idx == '0) begin
            rd_q[p*ROB_W +: ROB_W]   = '0;
            rd_v[p*DATA_W +: DATA_W] = '0;
         end else if (cm_valid && (cm_reg == idx) && (alias_q[idx] == cm_alias)) begin
            rd_q[p*ROB_W +: ROB_W]   = '0;
            rd_v[p*DATA_W +: DATA_W] = cm_data;
         end else begin
            rd_q[p*ROB_W +: ROB_W]   = alias_q[idx];
            rd_v[p*DATA_W +: DATA_W] = regs_q[idx];
         end
      end
   end

   // state update: commit applies on every ready cycle; flush, restore and normal cycles are mutually exclusive
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r]  <= '0;
            alias_q[r] <= '0;
         end
         for (int k = 0; k < NCKPT; k++)
            for (int r = 0; r < NREG; r++)
               ckpt_q[k][r] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (rdy) begin
         if (cm_en)
            regs_q[cm_reg] <= cm_data;
         for (int k = 0; k < NCKPT; k++)
            for (int r = 0; r < NREG; r++)
               ckpt_q[k][r] <= ckpt_cc[k][r];

         if (flush) begin
            for (int r = 0; r < NREG; r++)
               alias_q[r] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else if (ck_restore) begin
            head_q <= head_nx;
            if (restore_act) begin
               for (int r = 0; r < NREG; r++)
                  alias_q[r] <= ckpt_cc[ck_restore_id][r];
               tail_q  <= ck_restore_id;
               count_q <= {1'b0, rest_cnt};
            end else begin
               for (int r = 0; r < NREG; r++)
                  alias_q[r] <= alias_cc[r];
               count_q <= count_q - (CK_W+1)'(rel_acc);
            end
         end else begin
            for (int r = 0; r < NREG; r++)
               alias_q[r] <= alias_nx[r];
            if (alloc_acc) begin
               for (int r = 0; r < NREG; r++)
                  ckpt_q[tail_q][r] <= alias_nx[r];
               tail_q <= tail_q + 1'b1;
            end
            head_q  <= head_nx;
            count_q <= count_q + (CK_W+1)'(alloc_acc) - (CK_W+1)'(rel_acc);
         end
      end
   end

endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// Self-checking bench for rename_regfile_ckpt: directed scenarios plus a randomized run.
// Reference model tracks live checkpoints as a queue of slot ids, oldest first.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_rename_regfile_ckpt;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic [9:0]  rd_idx;
   logic [7:0]  rd_q;
   logic [63:0] rd_v;
   logic        ren_valid;
   logic [4:0]  ren_reg;
   logic [3:0]  ren_alias;
   logic        cm_valid;
   logic [4:0]  cm_reg;
   logic [3:0]  cm_alias;
   logic [31:0] cm_data;
   logic        ck_alloc;
   logic [1:0]  ck_alloc_id;
   logic        ck_full;
   logic [2:0]  ck_count;
   logic        ck_release, ck_restore;
   logic [1:0]  ck_restore_id;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rename_regfile_ckpt dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .rd_idx(rd_idx), .rd_q(rd_q), .rd_v(rd_v),
      .ren_valid(ren_valid), .ren_reg(ren_reg), .ren_alias(ren_alias),
      .cm_valid(cm_valid), .cm_reg(cm_reg), .cm_alias(cm_alias), .cm_data(cm_data),
      .ck_alloc(ck_alloc), .ck_alloc_id(ck_alloc_id), .ck_full(ck_full), .ck_count(ck_count),
      .ck_release(ck_release), .ck_restore(ck_restore), .ck_restore_id(ck_restore_id)
   );

   // ---------------- reference model ----------------
   logic [31:0] mreg   [32];
   logic [3:0]  malias [32];
   logic [3:0]  mck    [4][32];
   int          live [$];
   int          nxt;

   function automatic void model_clock();
      logic [3:0] na [32];
      int pos;
      bit full;
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            mreg[r] = '0; malias[r] = '0;
            for (int k = 0; k < 4; k++) mck[k][r] = '0;
         end
         live.delete();
         nxt = 0;
         return;
      end
      if (!rdy) return;
      for (int r = 0; r < 32; r++) na[r] = malias[r];
      if (cm_valid && cm_reg != 0) begin
         mreg[cm_reg] = cm_data;
         if (malias[cm_reg] == cm_alias) na[cm_reg] = '0;
         foreach (live[i])
            if (mck[live[i]][cm_reg] == cm_alias) mck[live[i]][cm_reg] = '0;
      end
      if (flush) begin
         for (int r = 0; r < 32; r++) malias[r] = '0;
         live.delete();
         nxt = 0;
      end else if (ck_restore) begin
         pos = -1;
         foreach (live[i]) if (live[i] == int'(ck_restore_id)) pos = i;
         assert (pos >= 0) else $error("restore to a dead checkpoint id %0d", ck_restore_id);
         if (pos >= 0) begin
            for (int r = 0; r < 32; r++) malias[r] = mck[ck_restore_id][r];
            if (ck_release && pos != 0) begin
               void'(live.pop_front());
               pos--;
            end
            while (live.size() > pos) live.delete(live.size() - 1);
            nxt = int'(ck_restore_id);
         end
      end else begin
         if (ren_valid && ren_reg != 0) na[ren_reg] = ren_alias;
         for (int r = 0; r < 32; r++) malias[r] = na[r];
         full = (live.size() == 4);
         if (ck_release && live.size() > 0) void'(live.pop_front());
         if (ck_alloc && !full) begin
            for (int r = 0; r < 32; r++) mck[nxt][r] = na[r];
            live.push_back(nxt);
            nxt = (nxt + 1) % 4;
         end
      end
   endfunction

   function automatic logic [3:0] exp_q(input logic [4:0] idx);
      if (idx == 0) return 4'd0;
      if (cm_valid && cm_reg == idx && malias[idx] == cm_alias) return 4'd0;
      return malias[idx];
   endfunction

   function automatic logic [31:0] exp_v(input logic [4:0] idx);
      if (idx == 0) return 32'd0;
      if (cm_valid && cm_reg == idx && malias[idx] == cm_alias) return cm_data;
      return mreg[idx];
   endfunction

   always @(posedge clk) model_clock();

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rdy = 1'b1; flush = 1'b0;
      ren_valid = 1'b0; ren_reg = '0; ren_alias = '0;
      cm_valid = 1'b0; cm_reg = '0; cm_alias = '0; cm_data = '0;
      ck_alloc = 1'b0; ck_release = 1'b0; ck_restore = 1'b0; ck_restore_id = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rd_idx = {5'd0, 5'd5};
      do_reset();
      @(negedge clk);
      total++; if (rd_q[3:0] !== 4'd0)  begin bad++; $display("FAIL reset_q_x5 got=%0h exp=0", rd_q[3:0]); end
      total++; if (rd_v[31:0] !== 32'd0) begin bad++; $display("FAIL reset_v_x5 got=%0h exp=0", rd_v[31:0]); end
      total++; if (rd_q[7:4] !== 4'd0)  begin bad++; $display("FAIL reset_q_x0 got=%0h exp=0", rd_q[7:4]); end
      total++; if (rd_v[63:32] !== 32'd0) begin bad++; $display("FAIL reset_v_x0 got=%0h exp=0", rd_v[63:32]); end
      total++; if ({ck_full, ck_count, ck_alloc_id} !== 6'd0) begin bad++; $display("FAIL reset_ck full=%0b count=%0d id=%0d exp 0/0/0", ck_full, ck_count, ck_alloc_id); end
      tick();
   endtask

   task automatic test_rename_commit();
      do_reset();
      rd_idx = {5'd5, 5'd5};
      ren_valid = 1'b1; ren_reg = 5'd5; ren_alias = 4'd3;
      @(negedge clk);
      total++; if (rd_q[3:0] !== 4'd0) begin bad++; $display("FAIL ren_same_cycle_hidden got=%0h exp=0", rd_q[3:0]); end
      tick(); idle();
      @(negedge clk);
      total++; if (rd_q[7:4] !== 4'd3) begin bad++; $display("FAIL ren_x5_q got=%0h exp=3", rd_q[7:4]); end
      cm_valid = 1'b1; cm_reg = 5'd5; cm_alias = 4'd3; cm_data = 32'hAB;
      #1;
      total++; if (rd_q[3:0] !== 4'd0 || rd_v[31:0] !== 32'hAB) begin bad++; $display("FAIL cm_forward q=%0h v=%0h exp 0/ab", rd_q[3:0], rd_v[31:0]); end
      tick(); idle();
      @(negedge clk);
      total++; if (rd_q[3:0] !== 4'd0 || rd_v[31:0] !== 32'hAB) begin bad++; $display("FAIL cm_retired q=%0h v=%0h exp 0/ab", rd_q[3:0], rd_v[31:0]); end
      ren_valid = 1'b1; ren_reg = 5'd5; ren_alias = 4'd6;
      tick(); idle();
      ren_valid = 1'b1; ren_reg = 5'd5; ren_alias = 4'd8;
      cm_valid = 1'b1; cm_reg = 5'd5; cm_alias = 4'd6; cm_data = 32'h11;
      tick(); idle();
      @(negedge clk);
      total++; if (rd_q[3:0] !== 4'd8 || rd_v[31:0] !== 32'h11) begin bad++; $display("FAIL ren_beats_clear q=%0h v=%0h exp 8/11", rd_q[3:0], rd_v[31:0]); end
   endtask

   task automatic test_ckpt_restore();
      do_reset();
      rd_idx = {5'd6, 5'd6};
      ren_valid = 1'b1; ren_reg = 5'd6; ren_alias = 4'd2;
      tick(); idle();
      ck_alloc = 1'b1;
      @(negedge clk);
      total++; if (ck_alloc_id !== 2'd0) begin bad++; $display("FAIL alloc_id_first got=%0d exp=0", ck_alloc_id); end
      tick(); idle();
      ren_valid = 1'b1; ren_reg = 5'd6; ren_alias = 4'd7;
      tick(); idle();
      @(negedge clk);
      total++; if (rd_q[3:0] !== 4'd7 || ck_count !== 3'd1) begin bad++; $display("FAIL pre_restore q=%0h count=%0d exp 7/1", rd_q[3:0], ck_count); end
      ck_restore = 1'b1; ck_restore_id = 2'd0;
      ren_valid = 1'b1; ren_reg = 5'd6; ren_alias = 4'd9; ck_alloc = 1'b1;
      tick(); idle();
      @(negedge clk);
      total++; if (rd_q[3:0] !== 4'd2 || ck_count !== 3'd0 || ck_alloc_id !== 2'd0) begin bad++; $display("FAIL restore q=%0h count=%0d id=%0d exp 2/0/0", rd_q[3:0], ck_count, ck_alloc_id); end
      // release then restore: head moves to 1, three allocs take ids 1..3
      ck_alloc = 1'b1; tick(); idle();
      ck_release = 1'b1; tick(); idle();
      ck_alloc = 1'b1; repeat (3) tick(); idle();
      ck_restore = 1'b1; ck_restore_id = 2'd1; ck_release = 1'b1;
      tick(); idle();
      @(negedge clk);
      total++; if (ck_count !== 3'd0 || ck_alloc_id !== 2'd1) begin bad++; $display("FAIL restore_head_rel count=%0d id=%0d exp 0/1", ck_count, ck_alloc_id); end
      ck_alloc = 1'b1; repeat (3) tick(); idle();
      ck_restore = 1'b1; ck_restore_id = 2'd3; ck_release = 1'b1;
      tick(); idle();
      @(negedge clk);
      total++; if (ck_count !== 3'd1 || ck_alloc_id !== 2'd3) begin bad++; $display("FAIL restore_with_rel count=%0d id=%0d exp 1/3", ck_count, ck_alloc_id); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      ck_release = 1'b1; tick(); idle();
      @(negedge clk);
      total++; if (ck_count !== 3'd0 || ck_alloc_id !== 2'd0) begin bad++; $display("FAIL release_empty count=%0d id=%0d exp 0/0", ck_count, ck_alloc_id); end
      ck_alloc = 1'b1; repeat (4) tick(); idle();
      @(negedge clk);
      total++; if (ck_full !== 1'b1 || ck_count !== 3'd4 || ck_alloc_id !== 2'd0) begin bad++; $display("FAIL full full=%0b count=%0d id=%0d exp 1/4/0", ck_full, ck_count, ck_alloc_id); end
      ck_alloc = 1'b1; tick(); idle();
      @(negedge clk);
      total++; if (ck_count !== 3'd4) begin bad++; $display("FAIL alloc_dropped count=%0d exp=4", ck_count); end
      ck_alloc = 1'b1; ck_release = 1'b1; tick(); idle();
      @(negedge clk);
      total++; if (ck_count !== 3'd3 || ck_full !== 1'b0 || ck_alloc_id !== 2'd0) begin bad++; $display("FAIL full_alloc_rel count=%0d full=%0b id=%0d exp 3/0/0", ck_count, ck_full, ck_alloc_id); end
      ck_alloc = 1'b1; tick(); idle();
      @(negedge clk);
      total++; if (ck_count !== 3'd4 || ck_alloc_id !== 2'd1) begin bad++; $display("FAIL wrap_alloc count=%0d id=%0d exp 4/1", ck_count, ck_alloc_id); end
   endtask

   task automatic test_scrub();
      do_reset();
      rd_idx = {5'd7, 5'd7};
      ren_valid = 1'b1; ren_reg = 5'd7; ren_alias = 4'd4; tick(); idle();
      ck_alloc = 1'b1; tick(); idle();
      ren_valid = 1'b1; ren_reg = 5'd7; ren_alias = 4'd9; tick(); idle();
      cm_valid = 1'b1; cm_reg = 5'd7; cm_alias = 4'd4; cm_data = 32'h55; tick(); idle();
      @(negedge clk);
      total++; if (rd_q[3:0] !== 4'd9 || rd_v[31:0] !== 32'h55) begin bad++; $display("FAIL stale_commit q=%0h v=%0h exp 9/55", rd_q[3:0], rd_v[31:0]); end
      ck_restore = 1'b1; ck_restore_id = 2'd0; tick(); idle();
      @(negedge clk);
      total++; if (rd_q[7:4] !== 4'd0 || rd_v[63:32] !== 32'h55) begin bad++; $display("FAIL scrub q=%0h v=%0h exp 0/55", rd_q[7:4], rd_v[63:32]); end
   endtask

   task automatic test_hold_flush();
      do_reset();
      rd_idx = {5'd9, 5'd9};
      ren_valid = 1'b1; ren_reg = 5'd9; ren_alias = 4'd5; ck_alloc = 1'b1; tick(); idle();
      rdy = 1'b0; flush = 1'b1;
      ren_valid = 1'b1; ren_reg = 5'd9; ren_alias = 4'd8;
      cm_valid = 1'b1; cm_reg = 5'd9; cm_alias = 4'd5; cm_data = 32'h77;
      ck_alloc = 1'b1; ck_release = 1'b1; ck_restore = 1'b1; ck_restore_id = 2'd0;
      tick(); idle();
      @(negedge clk);
      total++; if (rd_q[3:0] !== 4'd5 || rd_v[31:0] !== 32'd0) begin bad++; $display("FAIL hold_regs q=%0h v=%0h exp 5/0", rd_q[3:0], rd_v[31:0]); end
      total++; if (ck_count !== 3'd1 || ck_alloc_id !== 2'd1) begin bad++; $display("FAIL hold_ck count=%0d id=%0d exp 1/1", ck_count, ck_alloc_id); end
      flush = 1'b1; cm_valid = 1'b1; cm_reg = 5'd9; cm_alias = 4'd3; cm_data = 32'h99;
      tick(); idle();
      @(negedge clk);
      total++; if (rd_q[7:4] !== 4'd0 || rd_v[63:32] !== 32'h99) begin bad++; $display("FAIL flush_regs q=%0h v=%0h exp 0/99", rd_q[7:4], rd_v[63:32]); end
      total++; if (ck_count !== 3'd0 || ck_full !== 1'b0 || ck_alloc_id !== 2'd0) begin bad++; $display("FAIL flush_ck count=%0d full=%0b id=%0d exp 0/0/0", ck_count, ck_full, ck_alloc_id); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         idle();
         rdy        = ($urandom_range(0, 9) != 0);
         flush      = ($urandom_range(0, 63) == 0);
         rd_idx     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         ren_valid  = $urandom_range(0, 1);
         ren_reg    = 5'($urandom_range(0, 7));
         ren_alias  = 4'($urandom_range(1, 15));
         cm_valid   = $urandom_range(0, 1);
         cm_reg     = 5'($urandom_range(0, 7));
         cm_data    = $urandom;
         case ($urandom_range(0, 2))
            0: cm_alias = 4'($urandom_range(0, 15));
            1: cm_alias = malias[cm_reg];
            default: cm_alias = (live.size() > 0) ? mck[live[0]][cm_reg] : 4'($urandom_range(0, 15));
         endcase
         ck_alloc   = ($urandom_range(0, 2) == 0);
         ck_release = ($urandom_range(0, 3) == 0);
         if (live.size() > 0 && $urandom_range(0, 9) == 0) begin
            ck_restore    = 1'b1;
            ck_restore_id = 2'(live[$urandom_range(0, live.size() - 1)]);
         end
         @(negedge clk);
         total++; if (rd_q[3:0] !== exp_q(rd_idx[4:0])) begin bad++; $display("FAIL rnd_q0 n=%0d got=%0h exp=%0h", n, rd_q[3:0], exp_q(rd_idx[4:0])); end
         total++; if (rd_q[7:4] !== exp_q(rd_idx[9:5])) begin bad++; $display("FAIL rnd_q1 n=%0d got=%0h exp=%0h", n, rd_q[7:4], exp_q(rd_idx[9:5])); end
         total++; if (rd_v[31:0] !== exp_v(rd_idx[4:0])) begin bad++; $display("FAIL rnd_v0 n=%0d got=%0h exp=%0h", n, rd_v[31:0], exp_v(rd_idx[4:0])); end
         total++; if (rd_v[63:32] !== exp_v(rd_idx[9:5])) begin bad++; $display("FAIL rnd_v1 n=%0d got=%0h exp=%0h", n, rd_v[63:32], exp_v(rd_idx[9:5])); end
         total++; if (int'(ck_count) != live.size() || ck_full !== (live.size() == 4)) begin bad++; $display("FAIL rnd_count n=%0d got=%0d/%0b exp=%0d", n, ck_count, ck_full, live.size()); end
         total++; if (int'(ck_alloc_id) != nxt) begin bad++; $display("FAIL rnd_alloc_id n=%0d got=%0d exp=%0d", n, ck_alloc_id, nxt); end
         tick();
      end
      idle();
   endtask

   initial begin
      rst = 1'b0;
      rd_idx = '0;
      idle();
      test_reset();
      test_rename_commit();
      test_ckpt_restore();
      test_full_wrap();
      test_scrub();
      test_hold_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
